// File: rtl/binarizer_pkg.sv
// Shared constants and the saturating adder used by the pupil-path binarizer.
package binarizer_pkg;

  localparam int unsigned DATA_W_DEF = 10;
  localparam int unsigned CNT_W_DEF  = 20;

  localparam logic POL_BRIGHT = 1'b0;
  localparam logic POL_DARK   = 1'b1;

  // a + b clamped to max_v; operands up to 32 bits, zero-extended by callers
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max_v}) return max_v;
    return s[31:0];
  endfunction

endpackage

// File: rtl/frame_min_tracker.sv
// Running minimum of sampled pixels within a frame, plus a seen-any-pixel flag.
// Only built when AUTO_THRESH_EN is defined.
`ifdef AUTO_THRESH_EN
module frame_min_tracker
  import binarizer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSAMPLE,
  input  logic [DATA_W-1:0] iPIX,
  input  logic              iCLR,
  output logic [DATA_W-1:0] oMIN,
  output logic              oSEEN
);

  logic [DATA_W-1:0] min_q, min_d;
  logic              seen_q, seen_d;

  always_comb begin
    min_d  = min_q;
    seen_d = seen_q;
    if (iCLR) begin
      min_d  = '1;
      seen_d = 1'b0;
    end else if (iSAMPLE) begin
      min_d  = (iPIX < min_q) ? iPIX : min_q;
      seen_d = 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      min_q  <= '1;
      seen_q <= 1'b0;
    end else begin
      min_q  <= min_d;
      seen_q <= seen_d;
    end
  end

  assign oMIN  = min_q;
  assign oSEEN = seen_q;

endmodule
`endif

// File: rtl/binary_threshold_adapt.sv
// Pixel binarizer: threshold committed at frame start, per-frame foreground count.
// Define AUTO_THRESH_EN to build the previous-frame-minimum + offset auto threshold.
module binary_threshold_adapt
  import binarizer_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned THRESH_DEFAULT = 190,
  parameter int unsigned OFFSET_DEFAULT = 24
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iFVAL,
  input  logic              iDVAL,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iCFG_WR,
  input  logic [DATA_W-1:0] iCFG_THRESH,
  input  logic              iCFG_POL,
  input  logic              iCFG_AUTO,
  input  logic [DATA_W-1:0] iCFG_OFFSET,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [DATA_W-1:0] oTHRESH,
  output logic [CNT_W-1:0]  oCOUNT,
  output logic              oFRAME_DONE
);

  localparam logic [DATA_W-1:0] THR_RST = DATA_W'(THRESH_DEFAULT);
  localparam logic [DATA_W-1:0] PIX_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic              fval_q, fval_d;
  logic [DATA_W-1:0] sh_thresh_q, sh_thresh_d;
  logic              sh_pol_q, sh_pol_d;
  logic [DATA_W-1:0] act_thresh_q, act_thresh_d;
  logic              act_pol_q, act_pol_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dval_q, dval_d;
  logic [CNT_W-1:0]  fg_cnt_q, fg_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              done_q, done_d;

  logic frame_start, frame_end, tracked, fg_c;

  assign frame_start = iFVAL & ~fval_q;
  assign frame_end   = ~iFVAL & fval_q;
  assign tracked     = iFVAL & iDVAL;

`ifdef AUTO_THRESH_EN
  logic              sh_auto_q, sh_auto_d;
  logic [DATA_W-1:0] sh_offset_q, sh_offset_d;
  logic [DATA_W-1:0] act_offset_q, act_offset_d;
  logic [DATA_W-1:0] cand_q, cand_d;
  logic [DATA_W-1:0] min_c;
  logic              seen_c;

  frame_min_tracker #(.DATA_W(DATA_W)) u_min (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iSAMPLE (tracked),
    .iPIX    (iDATA),
    .iCLR    (frame_end),
    .oMIN    (min_c),
    .oSEEN   (seen_c)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{iCFG_AUTO, iCFG_OFFSET, DATA_W'(OFFSET_DEFAULT)};
`endif

  always_comb begin
    fval_d       = iFVAL;
    sh_thresh_d  = sh_thresh_q;
    sh_pol_d     = sh_pol_q;
    act_thresh_d = act_thresh_q;
    act_pol_d    = act_pol_q;
    fg_cnt_d     = fg_cnt_q;
    count_d      = count_q;
    done_d       = 1'b0;
`ifdef AUTO_THRESH_EN
    sh_auto_d    = sh_auto_q;
    sh_offset_d  = sh_offset_q;
    act_offset_d = act_offset_q;
    cand_d       = cand_q;
`endif

    if (iCFG_WR) begin
      sh_thresh_d = iCFG_THRESH;
      sh_pol_d    = iCFG_POL;
`ifdef AUTO_THRESH_EN
      sh_auto_d   = iCFG_AUTO;
      sh_offset_d = iCFG_OFFSET;
`endif
    end

    // Commit reads the pre-write shadow so a coincident write lands next frame
    if (frame_start) begin
      act_pol_d    = sh_pol_q;
      act_thresh_d = sh_thresh_q;
`ifdef AUTO_THRESH_EN
      act_offset_d = sh_offset_q;
      if (sh_auto_q) act_thresh_d = cand_q;
`endif
    end

    // Compare against the next active set so the frame-start pixel sees the new threshold
    fg_c   = (act_pol_d == POL_DARK) ? (iDATA < act_thresh_d) : (iDATA > act_thresh_d);
    data_d = (iDVAL && fg_c) ? PIX_MAX : '0;
    dval_d = iDVAL;

    if (frame_end) begin
      count_d  = fg_cnt_q;
      done_d   = 1'b1;
      fg_cnt_d = '0;
`ifdef AUTO_THRESH_EN
      if (seen_c) cand_d = DATA_W'(sat_add(32'(min_c), 32'(act_offset_q), 32'(PIX_MAX)));
`endif
    end else if (tracked && fg_c) begin
      fg_cnt_d = CNT_W'(sat_add(32'(fg_cnt_q), 32'd1, 32'(CNT_MAX)));
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      fval_q       <= 1'b0;
      sh_thresh_q  <= THR_RST;
      sh_pol_q     <= POL_BRIGHT;
      act_thresh_q <= THR_RST;
      act_pol_q    <= POL_BRIGHT;
      data_q       <= '0;
      dval_q       <= 1'b0;
      fg_cnt_q     <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
`ifdef AUTO_THRESH_EN
      sh_auto_q    <= 1'b0;
      sh_offset_q  <= DATA_W'(OFFSET_DEFAULT);
      act_offset_q <= DATA_W'(OFFSET_DEFAULT);
      cand_q       <= THR_RST;
`endif
    end else begin
      fval_q       <= fval_d;
      sh_thresh_q  <= sh_thresh_d;
      sh_pol_q     <= sh_pol_d;
      act_thresh_q <= act_thresh_d;
      act_pol_q    <= act_pol_d;
      data_q       <= data_d;
      dval_q       <= dval_d;
      fg_cnt_q     <= fg_cnt_d;
      count_q      <= count_d;
      done_q       <= done_d;
`ifdef AUTO_THRESH_EN
      sh_auto_q    <= sh_auto_d;
      sh_offset_q  <= sh_offset_d;
      act_offset_q <= act_offset_d;
      cand_q       <= cand_d;
`endif
    end
  end

  assign oDATA       = data_q;
  assign oDVAL       = dval_q;
  assign oTHRESH     = act_thresh_q;
  assign oCOUNT      = count_q;
  assign oFRAME_DONE = done_q;

endmodule

// File: tb/tb_binary_threshold_adapt.sv
// Self-checking bench for binary_threshold_adapt: frame-level reference model,
// directed literal checks, then randomized frames/config writes/resets.
module tb_binary_threshold_adapt;

  localparam int PMAX = 1023;
`ifdef AUTO_THRESH_EN
  localparam bit AUTO_BUILT = 1'b1;
`else
  localparam bit AUTO_BUILT = 1'b0;
`endif

  logic       iCLK = 1'b0;
  logic       iRST = 1'b0;
  logic       iFVAL = 1'b0, iDVAL = 1'b0, iCFG_WR = 1'b0, iCFG_POL = 1'b0, iCFG_AUTO = 1'b0;
  logic [9:0] iDATA = '0, iCFG_THRESH = '0, iCFG_OFFSET = '0;

  logic [9:0]  oDATA, oTHRESH, s_data, s_thr;
  logic        oDVAL, oFRAME_DONE, s_dval, s_done;
  logic [19:0] oCOUNT;
  logic [3:0]  s_count;

  int checks = 0;
  int failures = 0;

  always #5 iCLK = ~iCLK;

  binary_threshold_adapt dut (
    .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA),
    .iCFG_WR(iCFG_WR), .iCFG_THRESH(iCFG_THRESH), .iCFG_POL(iCFG_POL),
    .iCFG_AUTO(iCFG_AUTO), .iCFG_OFFSET(iCFG_OFFSET),
    .oDATA(oDATA), .oDVAL(oDVAL), .oTHRESH(oTHRESH), .oCOUNT(oCOUNT),
    .oFRAME_DONE(oFRAME_DONE)
  );

  binary_threshold_adapt #(.CNT_W(4)) dut_small (
    .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA),
    .iCFG_WR(iCFG_WR), .iCFG_THRESH(iCFG_THRESH), .iCFG_POL(iCFG_POL),
    .iCFG_AUTO(iCFG_AUTO), .iCFG_OFFSET(iCFG_OFFSET),
    .oDATA(s_data), .oDVAL(s_dval), .oTHRESH(s_thr), .oCOUNT(s_count),
    .oFRAME_DONE(s_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view with a queue of tracked pixels per frame
  int sh_thr, sh_pol, sh_auto, sh_off;
  int a_thr, a_pol, a_off, cand, m_prev;
  int px_q[$];
  int e_data, e_dval, e_thr, e_cnt, e_done;

  function automatic bit is_fg(input int d, input int thr, input int pol);
    return (pol != 0) ? (d < thr) : (d > thr);
  endfunction

  task automatic model_step();
    int cnt, mn, d;
    if (!iRST) begin
      m_prev = 0; sh_thr = 190; sh_pol = 0; sh_auto = 0; sh_off = 24;
      a_thr = 190; a_pol = 0; a_off = 24; cand = 190;
      px_q.delete();
      e_data = 0; e_dval = 0; e_thr = 190; e_cnt = 0; e_done = 0;
      return;
    end
    d = int'(iDATA);
    if (iFVAL && m_prev == 0) begin
      a_pol = sh_pol;
      a_off = sh_off;
      a_thr = (AUTO_BUILT && sh_auto != 0) ? cand : sh_thr;
    end
    e_data = (iDVAL && is_fg(d, a_thr, a_pol)) ? PMAX : 0;
    e_dval = int'(iDVAL);
    e_thr  = a_thr;
    e_done = 0;
    if (!iFVAL && m_prev != 0) begin
      cnt = 0;
      mn  = PMAX;
      foreach (px_q[i]) begin
        if (is_fg(px_q[i], a_thr, a_pol)) cnt++;
        if (px_q[i] < mn) mn = px_q[i];
      end
      e_cnt  = cnt;
      e_done = 1;
      if (px_q.size() > 0) cand = (mn + a_off > PMAX) ? PMAX : mn + a_off;
      px_q.delete();
    end else if (iFVAL && iDVAL) begin
      px_q.push_back(d);
    end
    if (iCFG_WR) begin
      sh_thr = int'(iCFG_THRESH); sh_pol = int'(iCFG_POL);
      sh_auto = int'(iCFG_AUTO); sh_off = int'(iCFG_OFFSET);
    end
    m_prev = int'(iFVAL);
  endtask

  // Compare process: outputs are meaningful every cycle
  always @(posedge iCLK) begin
    #1;
    model_step();
    chk("odata", oDATA, e_data);
    chk("odval", oDVAL, e_dval);
    chk("othresh", oTHRESH, e_thr);
    chk("ocount", oCOUNT, e_cnt);
    chk("odone", oFRAME_DONE, e_done);
    chk("s_odata", s_data, e_data);
    chk("s_odval", s_dval, e_dval);
    chk("s_othresh", s_thr, e_thr);
    chk("s_ocount_sat", s_count, (e_cnt > 15) ? 15 : e_cnt);
    chk("s_odone", s_done, e_done);
  end

  task automatic set_cfg(input int thr, input bit pol, input bit au, input int off);
    iCFG_THRESH = 10'(thr); iCFG_POL = pol; iCFG_AUTO = au; iCFG_OFFSET = 10'(off);
  endtask

  // Drive one cycle of input; returns with that cycle's outputs visible
  task automatic pix(input bit f, input bit v, input int d, input bit wr);
    @(negedge iCLK);
    iFVAL = f; iDVAL = v; iDATA = 10'(d); iCFG_WR = wr;
    @(posedge iCLK);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f;
    int d, r;

    repeat (2) @(posedge iCLK);
    #2;
    chk("rst_thresh", oTHRESH, 190);
    chk("rst_count", oCOUNT, 0);
    chk("rst_data", oDATA, 0);
    chk("rst_dval", oDVAL, 0);
    chk("rst_done", oFRAME_DONE, 0);
    @(negedge iCLK);
    iRST = 1'b1;

    // Bright manual, threshold 190
    pix(0, 0, 0, 0);
    pix(1, 0, 0, 0);
    pix(1, 1, 189, 0);  chk("bright_189", oDATA, 0);
    pix(1, 1, 190, 0);  chk("bright_190_eq", oDATA, 0);
    pix(1, 1, 191, 0);  chk("bright_191", oDATA, 10'h3FF);
    pix(1, 1, 1023, 0); chk("bright_1023", oDATA, 10'h3FF);
    pix(0, 0, 0, 0);    chk("bright_done", oFRAME_DONE, 1); chk("bright_count", oCOUNT, 2);
    pix(0, 0, 0, 0);    chk("bright_done_1cyc", oFRAME_DONE, 0);

    // Mid-frame write only takes effect next frame
    set_cfg(100, 1, 0, 24);
    pix(1, 0, 0, 0);
    pix(1, 1, 50, 0);   chk("mid_50_old", oDATA, 0);
    pix(1, 1, 100, 1);  chk("mid_100_old", oDATA, 0);
    pix(1, 1, 200, 0);  chk("mid_200_old", oDATA, 10'h3FF); chk("mid_thr_old", oTHRESH, 190);
    pix(0, 0, 0, 0);    chk("mid_count1", oCOUNT, 1);
    pix(1, 1, 50, 0);   chk("next_50_dark", oDATA, 10'h3FF); chk("next_thr", oTHRESH, 100);
    pix(1, 1, 100, 0);  chk("next_100_eq", oDATA, 0);
    pix(1, 1, 99, 0);   chk("next_99", oDATA, 10'h3FF);
    pix(0, 0, 0, 0);    chk("next_count", oCOUNT, 2);

    // Write coincident with frame start
    set_cfg(500, 0, 0, 24);
    pix(0, 0, 0, 0);
    pix(1, 1, 60, 1);   chk("fs_wr_thr_old", oTHRESH, 100); chk("fs_wr_60", oDATA, 10'h3FF);
    pix(1, 1, 600, 0);  chk("fs_wr_600", oDATA, 0);
    pix(0, 0, 0, 0);
    pix(1, 1, 501, 0);  chk("fs_wr_thr_new", oTHRESH, 500); chk("fs_wr_501", oDATA, 10'h3FF);
    pix(1, 1, 500, 0);  chk("fs_wr_500_eq", oDATA, 0);
    pix(0, 0, 0, 0);    chk("fs_wr_count", oCOUNT, 1);

    // Counter saturation (small instance) and truncated last pixel
    set_cfg(100, 0, 0, 24);
    pix(0, 0, 0, 1);
    pix(1, 0, 0, 0);
    repeat (20) pix(1, 1, 500, 0);
    pix(0, 1, 700, 0);  chk("trunc_data", oDATA, 10'h3FF);
                        chk("sat_count20", oCOUNT, 20); chk("sat_count15", s_count, 15);
    pix(0, 0, 0, 0);

`ifdef AUTO_THRESH_EN
    set_cfg(100, 0, 1, 24);
    pix(0, 0, 0, 1);
    pix(1, 1, 40, 0);
    pix(1, 1, 300, 0);
    pix(0, 0, 0, 0);
    pix(1, 1, 1010, 0); chk("auto_64", oTHRESH, 64);
    pix(1, 1, 1020, 0);
    pix(0, 0, 0, 0);
    pix(1, 0, 0, 0);    chk("auto_sat_1023", oTHRESH, 1023);
    pix(1, 0, 0, 0);
    pix(0, 0, 0, 0);
    pix(1, 0, 0, 0);    chk("auto_empty_keep", oTHRESH, 1023);
    pix(0, 0, 0, 0);
    set_cfg(100, 0, 0, 24);
    pix(0, 0, 0, 1);
`endif

    // Reset asserted mid-frame
    set_cfg(300, 1, 0, 24);
    pix(0, 0, 0, 1);
    repeat (3) pix(1, 1, 10, 0);
    pix(0, 0, 0, 0);    chk("pre_rst_count", oCOUNT, 3);
    pix(1, 1, 10, 0);   chk("pre_rst_thr", oTHRESH, 300);
    pix(1, 1, 10, 0);
    @(negedge iCLK);
    iRST = 1'b0; iFVAL = 1'b1; iDVAL = 1'b1; iDATA = 10'd500;
    #1;
    chk("mrst_thr", oTHRESH, 190);
    chk("mrst_count", oCOUNT, 0);
    chk("mrst_data", oDATA, 0);
    chk("mrst_dval", oDVAL, 0);
    chk("mrst_done", oFRAME_DONE, 0);
    @(posedge iCLK);
    #2;
    @(negedge iCLK);
    iRST = 1'b1;
    @(posedge iCLK);
    #2;
    chk("post_rst_thr", oTHRESH, 190);
    chk("post_rst_data", oDATA, 10'h3FF);
    pix(1, 1, 500, 0);
    pix(1, 1, 500, 0);
    pix(0, 0, 0, 0);    chk("post_rst_count", oCOUNT, 3);

    // Randomized frames, config writes and occasional resets
    f = 1'b0;
    repeat (4000) begin
      if (f) f = ($urandom_range(0, 19) != 0);
      else   f = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) != 0) d = int'($urandom_range(0, PMAX));
      else d = a_thr + int'($urandom_range(0, 4)) - 2;
      if (d < 0) d = 0;
      if (d > PMAX) d = PMAX;
      r = int'($urandom_range(0, 2));
      set_cfg((r == 0) ? 0 : (r == 1) ? PMAX : int'($urandom_range(0, PMAX)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? PMAX : int'($urandom_range(0, 64)));
      if ($urandom_range(0, 799) == 0) begin
        @(negedge iCLK);
        iRST = 1'b0;
        @(posedge iCLK);
        #2;
        @(negedge iCLK);
        iRST = 1'b1;
      end
      pix(f, $urandom_range(0, 9) < 7, d, $urandom_range(0, 39) == 0);
    end
    pix(0, 0, 0, 0);
    pix(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/binary_threshold_adapt.md
# binary_threshold_adapt

Parametrised pixel binarizer for the pupil-search video path. It sits between the camera/grayscale stage and the pupil locator. It thresholds each valid pixel to all-ones or all-zeros with selectable polarity, using a threshold that only changes at frame boundaries. An optional auto mode derives each frame's threshold from the previous frame's minimum luminance plus an offset. It also reports the per-frame foreground pixel count.

## Interface
- DATA_W, 10, pixel width
- CNT_W, 20, foreground counter width
- THRESH_DEFAULT, 190, active threshold after reset
- OFFSET_DEFAULT, 24, auto-mode offset after reset
- iCLK  in  1  clock
- iRST  in  1  reset, asynchronous, active-low
- iFVAL  in  1  frame valid; high for the whole frame
- iDVAL  in  1  pixel valid
- iDATA  in  DATA_W  pixel value
- iCFG_WR  in  1  config write strobe; captures the four iCFG_* fields
- iCFG_THRESH  in  DATA_W  manual threshold
- iCFG_POL  in  1  0: foreground = pixel > threshold; 1: foreground = pixel < threshold (dark pupil)
- iCFG_AUTO  in  1  1: auto threshold mode
- iCFG_OFFSET  in  DATA_W  auto-mode offset added to the frame minimum
- oDATA  out  DATA_W  all-ones for foreground, zero otherwise
- oDVAL  out  1  iDVAL delayed one cycle
- oTHRESH  out  DATA_W  threshold in force for the current frame
- oCOUNT  out  CNT_W  foreground pixel count of the last completed frame
- oFRAME_DONE  out  1  one-cycle pulse when oCOUNT updates

## Operation
- **Shadow registers.** iCFG_WR loads the shadow registers (thresh, pol, auto, offset) in any cycle.
- **Frame start commit.** Frame start is the cycle where iFVAL=1 and the registered iFVAL=0. On that cycle the shadow registers are copied to the active set.
  - Threshold source: manual (shadow thresh) when auto=0; the auto candidate when auto=1.
- **Same-cycle write at frame start.** If iCFG_WR coincides with frame start, the active set receives the pre-write shadow value. The new value applies from the next frame.
- **Same-cycle threshold use.** The compare on the frame-start cycle uses the newly committed threshold and polarity, via a mux on the next value.
- **Compare.**
  - iDVAL=1: oDATA is all-ones when the pixel satisfies the polarity test, else 0.
  - iDVAL=0: oDATA = 0.
  - A pixel equal to the threshold is never foreground.
- **Tracking.** Only pixels with iDVAL=1 and iFVAL=1 update the frame minimum and the foreground counter. Pixels with iDVAL=1 while iFVAL=0 are still thresholded but not tracked.
- **Counter.** Saturates at 2^CNT_W−1.
- **Frame end.** Frame end is the cycle where iFVAL=0 and the registered iFVAL=1. On that cycle:
  - oCOUNT latches the counter and oFRAME_DONE pulses.
  - The counter clears and the frame minimum resets to all-ones.
- **Auto candidate.** Computed at frame end as saturating add of min + offset, clamped to 2^DATA_W−1.
  - If the frame had no tracked pixels, the candidate keeps its previous value.
  - After reset the candidate is THRESH_DEFAULT.
- **Truncated frame.** iFVAL falling while a pixel is valid: that pixel is included in neither the count nor the minimum.

## Timing
- Pixel latency: 1 cycle, iDATA/iDVAL to oDATA/oDVAL.
- oFRAME_DONE and the updated oCOUNT are asserted in the cycle after the frame-end cycle, for exactly one cycle.
- oTHRESH updates in the cycle after frame start.
- Reset values:
  - oDATA=0, oDVAL=0, oCOUNT=0, oFRAME_DONE=0.
  - oTHRESH=THRESH_DEFAULT; auto candidate = THRESH_DEFAULT.
  - Shadow registers: thresh=THRESH_DEFAULT, offset=OFFSET_DEFAULT, pol=0, auto=0.
  - Registered iFVAL=0, minimum = all-ones, counter=0.
- Reset asserted mid-frame: all state returns to reset values immediately. If iFVAL is still high after release, the next cycle is treated as a frame start (registered iFVAL=0).

## Configuration
- AUTO_THRESH_EN defined: the minimum tracker, offset add and auto candidate are built; iCFG_AUTO selects the threshold source.
- AUTO_THRESH_EN undefined:
  - The minimum tracker, offset add and auto candidate are removed.
  - iCFG_AUTO and iCFG_OFFSET are ignored; the threshold is always the manual shadow value committed at frame start.
  - Counting, polarity and latency are unchanged.

## Structure
- **Package binarizer_pkg:**
  - default DATA_W/CNT_W constants
  - polarity encoding constants (POL_BRIGHT=0, POL_DARK=1)
  - saturating-add function used for the auto candidate and the counter
- **Sub-module frame_min_tracker (under AUTO_THRESH_EN):**
  - inputs: iCLK, iRST, sample strobe, pixel, frame-end clear
  - outputs: minimum and a seen-any-pixel flag

## Test plan
- **Bright manual:** after reset, pol=0, a frame of pixels 189,190,191,1023 → oDATA 0,0,3FF,3FF one cycle later; oCOUNT=2 with oFRAME_DONE pulse after iFVAL falls.
- **Mid-frame write:** iCFG_WR thresh=100, pol=1 mid-frame → current frame unchanged at 190, pol=0; next frame pixel 50 → 3FF, pixel 100 → 0; oTHRESH=100 from the cycle after that frame's start.
- **Auto mode:** auto=1, offset=24, frame minimum 40 → next frame oTHRESH=64. Frame minimum 1010 with offset 24 → 1023 (saturated). A frame with no valid pixels → threshold unchanged.
- **Write at frame start:** iCFG_WR on the same cycle as iFVAL rising → that frame uses the old threshold; the following frame uses the new one.
- **Counter saturation:** CNT_W=4, 20 foreground pixels → oCOUNT=15.
- **Reset mid-frame:** iRST low mid-frame → all outputs at reset values that cycle. After release with iFVAL high, frame start is committed and counting restarts from 0.
